reg_file_banked: RTL and testbench
==================================

Name: reg_file_banked

Overview:
- Parametrised successor to the core's single-bank register file.
- Adds two independent read ports, a parametrised accumulator index, and an asynchronous active-low reset.
- Adds a shadow bank with a sequential save/restore engine, used for interrupt/context switching.
- Sits between the decoder/ALU and writeback; the accumulator output feeds the ALU directly.

Parameters:
- W, 8, data width in bits
- D, 4, address width; register count N = 2**D
- ACC_IDX, 0, index of the register driven on acc_out
- PCW, 11, program-counter width (trace only)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- pc  input  PCW  current program counter (trace only; no functional effect)
- write_enabled  input  1  commit wr_data to wr_addr
- wr_addr  input  D  write destination
- wr_data  input  W  write data
- reg_to_reg  input  1  copy regs[mov_src] to regs[mov_dst]
- mov_src  input  D  move source
- mov_dst  input  D  move destination
- rd_a_addr  input  D  read port A address
- rd_a_data  output  W  regs[rd_a_addr], combinational
- rd_b_addr  input  D  read port B address
- rd_b_data  output  W  regs[rd_b_addr], combinational
- acc_out  output  W  regs[ACC_IDX], combinational
- save_req  input  1  start copy of live bank to shadow bank
- restore_req  input  1  start copy of shadow bank to live bank
- busy  output  1  save/restore in progress
- done  output  1  one-cycle pulse when save/restore completes

Behaviour:
- Reset (rst_n low, asynchronous): all live and shadow registers = 0; FSM = IDLE; internal index = 0; busy = 0; done = 0. All read outputs therefore read 0.
- Reset mid-save or mid-restore: operation abandoned; both banks cleared; no done pulse.
- Reads are purely combinational from the live bank, with no bypass. A write committed at edge k is visible on the read ports after edge k.
- Commit priority in IDLE:
  - reg_to_reg beats write_enabled; a simultaneous write is dropped.
  - mov_src == mov_dst leaves the register unchanged.
  - Any write to ACC_IDX updates acc_out next cycle.
- FSM states: IDLE, SAVE, RESTORE, FIN.
  - IDLE -> SAVE on save_req. SAVE has priority if save_req and restore_req are both high.
  - IDLE -> RESTORE on restore_req.
  - SAVE: each cycle shadow[idx] <= live[idx], then idx++. After idx = N-1 is copied -> FIN.
  - RESTORE: each cycle live[idx] <= shadow[idx], then idx++. After idx = N-1 is copied -> FIN.
  - FIN: done = 1 for exactly one cycle; idx <= 0; -> IDLE.
- busy = 1 in SAVE, RESTORE and FIN; 0 in IDLE.
- Total operation = N+1 cycles from the accepting edge to the return to IDLE.
- While busy:
  - write_enabled and reg_to_reg are ignored (dropped, not queued); the sequencer must stall.
  - save_req and restore_req are ignored.
  - Read ports stay live. During RESTORE, reads of already-copied indices return shadow values; uncopied indices return old values.
- idx is D+1 bits wide internally to detect the terminal count without wrap ambiguity.
- Back-to-back: a request held high on the FIN->IDLE edge is not seen until the IDLE cycle, so the minimum spacing between operations is N+2 cycles.

Optional Feature:
- Macro: REGFILE_TRACE_EN
- Defined: on every committed live-bank write (write, move, or restore step), $display prints pc, source kind (WR/MOV/RST), address and data. On done, it prints "SAVE DONE" or "RESTORE DONE".
- Undefined: no simulation output. Functional behaviour and synthesised logic are identical in both cases.

Test Plan:
- Reset then write sequence (W=8, D=4): write 0x3C to r5 -> rd_a_data at addr 5 reads 0x3C the cycle after the edge; acc_out = 0x00.
- Simultaneous write_enabled (r2 <= 0xFF) and reg_to_reg (r2 <= r5 = 0x3C) -> r2 = 0x3C; 0xFF dropped.
- Write 0x11..0x1F into r1..r15; pulse save_req -> busy high 17 cycles; done pulses once on cycle 17. Then overwrite r1 <= 0xAA; pulse restore_req -> after done, r1 reads 0x11 and every other register matches its saved value.
- During SAVE, assert write_enabled r4 <= 0x99 -> the write is ignored; r4 and shadow[4] both hold the pre-save value.
- Assert save_req and restore_req together in IDLE -> SAVE is executed and the live bank is unchanged.
- Drop rst_n for one cycle at idx = 7 of a RESTORE -> busy = 0 immediately; all reads = 0; no done pulse; a later save_req works normally.

Source files
------------

// File: rtl/reg_file_banked.sv
// reg_file_banked: banked register file, two read ports, accumulator tap, shadow save/restore sequencer; optional trace via REGFILE_TRACE_EN
module reg_file_banked #(
   parameter int W       = 8,
   parameter int D       = 4,
   parameter int ACC_IDX = 0,
   parameter int PCW     = 11
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic [PCW-1:0] pc,
   input  logic           write_enabled,
   input  logic [D-1:0]   wr_addr,
   input  logic [W-1:0]   wr_data,
   input  logic           reg_to_reg,
   input  logic [D-1:0]   mov_src,
   input  logic [D-1:0]   mov_dst,
   input  logic [D-1:0]   rd_a_addr,
   output logic [W-1:0]   rd_a_data,
   input  logic [D-1:0]   rd_b_addr,
   output logic [W-1:0]   rd_b_data,
   output logic [W-1:0]   acc_out,
   input  logic           save_req,
   input  logic           restore_req,
   output logic           busy,
   output logic           done
);
   localparam int N = 1 << D;
   localparam logic [D-1:0] ACC = D'(ACC_IDX);
   localparam logic [D:0] LAST = (D+1)'(N-1);
   typedef enum logic [1:0] {IDLE, SAVE, RESTORE, FIN} state_t;
   state_t state;
   logic [D:0] idx;
   logic [D-1:0] ix;
   logic [W-1:0] live [N];
   logic [W-1:0] shadow [N];
   logic unused_pc;
   assign ix = idx[D-1:0];
   assign rd_a_data = live[rd_a_addr];
   assign rd_b_data = live[rd_b_addr];
   assign acc_out = live[ACC];
   assign unused_pc = ^pc;
   // sequencer and both banks; host writes only commit while idle, moves beat writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         for (int i = 0; i < N; i++) begin
            live[i] <= '0;
            shadow[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (save_req) begin
                  state <= SAVE;
                  busy <= 1'b1;
               end else if (restore_req) begin
                  state <= RESTORE;
                  busy <= 1'b1;
               end
               if (reg_to_reg) live[mov_dst] <= live[mov_src];
               else if (write_enabled) live[wr_addr] <= wr_data;
            end
            SAVE: begin
               shadow[ix] <= live[ix];
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  state <= FIN;
                  done <= 1'b1;
               end
            end
            RESTORE: begin
               live[ix] <= shadow[ix];
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  state <= FIN;
                  done <= 1'b1;
               end
            end
            default: begin
               idx <= '0;
               busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
`ifdef REGFILE_TRACE_EN
   // report every committed live-bank write and each completed operation
   always @(posedge clk) begin
      if (rst_n && state == IDLE && reg_to_reg) $display("pc=%0h MOV r%0d=%0h", pc, mov_dst, live[mov_src]);
      else if (rst_n && state == IDLE && write_enabled) $display("pc=%0h WR r%0d=%0h", pc, wr_addr, wr_data);
      if (rst_n && state == RESTORE) $display("pc=%0h RST r%0d=%0h", pc, ix, shadow[ix]);
      if (rst_n && state == SAVE && idx == LAST) $display("SAVE DONE");
      if (rst_n && state == RESTORE && idx == LAST) $display("RESTORE DONE");
   end
`endif
endmodule

// File: tb/tb_reg_file_banked.sv
// tb_reg_file_banked: scoreboard bench for reg_file_banked (default W=8, D=4)
module tb_reg_file_banked;
   localparam int N = 16;
   typedef struct packed {logic [3:0] a; logic [7:0] d;} exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [10:0] pc = '0;
   logic write_enabled = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic reg_to_reg = 1'b0;
   logic [3:0] mov_src = '0;
   logic [3:0] mov_dst = '0;
   logic [3:0] rd_a_addr = '0;
   logic [3:0] rd_b_addr = '0;
   logic [7:0] rd_a_data, rd_b_data, acc_out;
   logic save_req = 1'b0;
   logic restore_req = 1'b0;
   logic busy, done;
   exp_t sb[$];
   logic [7:0] model [N];
   int passed = 0;
   int total = 0;

   reg_file_banked dut (
      .clk(clk), .rst_n(rst_n), .pc(pc),
      .write_enabled(write_enabled), .wr_addr(wr_addr), .wr_data(wr_data),
      .reg_to_reg(reg_to_reg), .mov_src(mov_src), .mov_dst(mov_dst),
      .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
      .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
      .acc_out(acc_out), .save_req(save_req), .restore_req(restore_req),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      pc = pc + 1'b1;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      write_enabled = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
      write_enabled = 1'b0;
      model[a] = d;
   endtask

   task automatic push_bank();
      for (int i = 0; i < N; i++) sb.push_back({4'(i), model[i]});
   endtask

   task automatic check_bank(input string tag);
      exp_t e;
      logic [3:0] b;
      push_bank();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         b = ~e.a;
         rd_a_addr = e.a;
         rd_b_addr = b;
         step();
         total += 2;
         if (rd_a_data !== e.d) $display("FAIL %s rd_a r%0d: got %0h expected %0h", tag, e.a, rd_a_data, e.d);
         else passed++;
         if (rd_b_data !== model[b]) $display("FAIL %s rd_b r%0d: got %0h expected %0h", tag, b, rd_b_data, model[b]);
         else passed++;
      end
      total++;
      if (acc_out !== model[0]) $display("FAIL %s acc_out: got %0h expected %0h", tag, acc_out, model[0]);
      else passed++;
   endtask

   task automatic run_op(input bit inject, input bit hold, output int nbusy, output int ndone, output int done_at);
      nbusy = 0;
      ndone = 0;
      done_at = 0;
      step();
      if (!hold) begin
         save_req = 1'b0;
         restore_req = 1'b0;
      end
      for (int c = 1; c <= 40 && busy; c++) begin
         nbusy++;
         if (done) begin
            ndone++;
            done_at = c;
         end
         if (inject && c == 2) begin
            write_enabled = 1'b1;
            wr_addr = 4'd4;
            wr_data = 8'h99;
            reg_to_reg = 1'b1;
            mov_src = 4'd1;
            mov_dst = 4'd2;
         end
         if (inject && c == 4) begin
            write_enabled = 1'b0;
            reg_to_reg = 1'b0;
         end
         step();
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      rd_a_addr = 4'd5;
      rd_b_addr = 4'd9;
      #1;
      total += 5;
      if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else passed++;
      if (done !== 1'b0) $display("FAIL reset done: got %b expected 0", done); else passed++;
      if (acc_out !== 8'h00) $display("FAIL reset acc_out: got %0h expected 0", acc_out); else passed++;
      if (rd_a_data !== 8'h00) $display("FAIL reset rd_a: got %0h expected 0", rd_a_data); else passed++;
      if (rd_b_data !== 8'h00) $display("FAIL reset rd_b: got %0h expected 0", rd_b_data); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) model[i] = 8'h00;
      step();
      check_bank("reset_bank");
   endtask

   task automatic test_write();
      rd_a_addr = 4'd5;
      write_enabled = 1'b1;
      wr_addr = 4'd5;
      wr_data = 8'h3C;
      #1;
      total++;
      if (rd_a_data !== 8'h00) $display("FAIL write no_bypass: got %0h expected 0", rd_a_data); else passed++;
      @(negedge clk);
      step();
      write_enabled = 1'b0;
      model[5] = 8'h3C;
      total += 2;
      if (rd_a_data !== 8'h3C) $display("FAIL write r5: got %0h expected 3c", rd_a_data); else passed++;
      if (acc_out !== 8'h00) $display("FAIL write acc_out: got %0h expected 0", acc_out); else passed++;
   endtask

   task automatic test_priority();
      write_enabled = 1'b1;
      wr_addr = 4'd2;
      wr_data = 8'hFF;
      reg_to_reg = 1'b1;
      mov_src = 4'd5;
      mov_dst = 4'd2;
      step();
      write_enabled = 1'b0;
      reg_to_reg = 1'b0;
      model[2] = 8'h3C;
      do_write(4'd7, 8'h5A);
      reg_to_reg = 1'b1;
      mov_src = 4'd7;
      mov_dst = 4'd7;
      step();
      reg_to_reg = 1'b0;
      check_bank("priority");
   endtask

   task automatic test_acc();
      do_write(4'd0, 8'h42);
      total++;
      if (acc_out !== 8'h42) $display("FAIL acc update: got %0h expected 42", acc_out); else passed++;
   endtask

   task automatic test_save_restore();
      int nb, nd, da;
      for (int i = 1; i < N; i++) do_write(4'(i), 8'(8'h10 + i));
      save_req = 1'b1;
      run_op(1'b1, 1'b0, nb, nd, da);
      total += 3;
      if (nb != 17) $display("FAIL save busy_cycles: got %0d expected 17", nb); else passed++;
      if (nd != 1) $display("FAIL save done_count: got %0d expected 1", nd); else passed++;
      if (da != 17) $display("FAIL save done_cycle: got %0d expected 17", da); else passed++;
      check_bank("after_save");
      do_write(4'd1, 8'hAA);
      rd_a_addr = 4'd1;
      #1;
      total++;
      if (rd_a_data !== 8'hAA) $display("FAIL overwrite r1: got %0h expected aa", rd_a_data); else passed++;
      @(negedge clk);
      restore_req = 1'b1;
      run_op(1'b0, 1'b0, nb, nd, da);
      model[1] = 8'h11;
      total += 2;
      if (nb != 17) $display("FAIL restore busy_cycles: got %0d expected 17", nb); else passed++;
      if (nd != 1 || da != 17) $display("FAIL restore done: got count %0d cycle %0d expected 1 at 17", nd, da); else passed++;
      check_bank("after_restore");
   endtask

   task automatic test_both_req();
      int nb, nd, da;
      do_write(4'd3, 8'h77);
      save_req = 1'b1;
      restore_req = 1'b1;
      run_op(1'b0, 1'b0, nb, nd, da);
      total++;
      if (nb != 17 || nd != 1) $display("FAIL both_req op: got busy %0d done %0d expected 17 and 1", nb, nd); else passed++;
      check_bank("both_req_live");
      do_write(4'd3, 8'h00);
      restore_req = 1'b1;
      run_op(1'b0, 1'b0, nb, nd, da);
      model[3] = 8'h77;
      check_bank("both_req_shadow");
   endtask

   task automatic test_back_to_back();
      int nb, nd, da;
      save_req = 1'b1;
      run_op(1'b0, 1'b1, nb, nd, da);
      total += 2;
      if (nb != 17 || da != 17) $display("FAIL b2b first: got busy %0d done_at %0d expected 17 and 17", nb, da); else passed++;
      if (busy !== 1'b0) $display("FAIL b2b idle_gap busy: got %b expected 0", busy); else passed++;
      run_op(1'b0, 1'b0, nb, nd, da);
      total++;
      if (nb != 17 || nd != 1 || da != 17) $display("FAIL b2b second: got busy %0d done %0d at %0d expected 17,1,17", nb, nd, da); else passed++;
   endtask

   task automatic test_reset_mid();
      int nb, nd, da;
      rd_a_addr = 4'd5;
      rd_b_addr = 4'd1;
      restore_req = 1'b1;
      step();
      restore_req = 1'b0;
      for (int c = 1; c < 8; c++) step();
      rst_n = 1'b0;
      #1;
      total += 4;
      if (busy !== 1'b0) $display("FAIL midreset busy: got %b expected 0", busy); else passed++;
      if (rd_a_data !== 8'h00) $display("FAIL midreset rd_a: got %0h expected 0", rd_a_data); else passed++;
      if (rd_b_data !== 8'h00) $display("FAIL midreset rd_b: got %0h expected 0", rd_b_data); else passed++;
      if (acc_out !== 8'h00) $display("FAIL midreset acc_out: got %0h expected 0", acc_out); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         total++;
         if (done !== 1'b0) $display("FAIL midreset done: got %b expected 0", done); else passed++;
         step();
      end
      for (int i = 0; i < N; i++) model[i] = 8'h00;
      save_req = 1'b1;
      run_op(1'b0, 1'b0, nb, nd, da);
      total++;
      if (nb != 17 || nd != 1 || da != 17) $display("FAIL post_reset save: got busy %0d done %0d at %0d expected 17,1,17", nb, nd, da); else passed++;
      check_bank("post_reset");
   endtask

   initial begin
      test_reset();
      test_write();
      test_priority();
      test_acc();
      test_save_restore();
      test_both_req();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
